boot_sequencer: RTL and testbench

Boot-time loader that sits between the boot ROM, the instruction memory write port and the CPU reset input in `top`. After system reset, or on a restart request, it holds the CPU in reset and copies `BOOT_WORDS` words from the boot ROM into instruction memory at one word per cycle. It then keeps the CPU in reset for `HOLD_CYCLES` more cycles and releases it. This replaces testbench-side memory preloading with an in-design boot path.

---
 rtl/boot_pkg.sv | 12 +
 rtl/boot_sequencer.sv | 108 ++++++++++
 tb/tb_boot_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types for the boot loader: FSM state encoding.
package boot_pkg;

  typedef enum logic [2:0] {
    START,
    COPY,
    DRAIN,
    HOLD,
    DONE
  } boot_state_t;

endpackage

// File: rtl/boot_sequencer.sv
// Boot loader: holds the CPU in reset, copies BOOT_WORDS words from boot ROM
// into instruction memory, stretches reset by HOLD_CYCLES, then releases it.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BOOT_WORDS  = 64,
  parameter int unsigned BOOT_BASE   = 0,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned RD_W = $clog2(BOOT_WORDS + 1);
  localparam int unsigned HC_W = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [RD_W-1:0] RD_END  = RD_W'(BOOT_WORDS);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

  // The copied window must fit the address space without wrapping.
  if (BOOT_WORDS < 1 ||
      64'(BOOT_BASE) + 64'(BOOT_WORDS) > (64'd1 << ADDR_W)) begin : g_bad_cfg
    $error("boot_sequencer: BOOT_BASE+BOOT_WORDS exceeds 2**ADDR_W or BOOT_WORDS is 0");
  end

  boot_state_t       state, state_n;
  logic [RD_W-1:0]   rd, rd_n;
  logic [HC_W-1:0]   hc, hc_n;
  logic              rom_en_n;
  logic [ADDR_W-1:0] rom_addr_n;

  assign imem_wdata_o = rom_data_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= START;
      rd          <= '0;
      hc          <= '0;
      rom_en_o    <= 1'b0;
      rom_addr_o  <= '0;
      imem_we_o   <= 1'b0;
      imem_addr_o <= '0;
      cpu_reset_o <= 1'b1;
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
    end else begin
      state       <= state_n;
      rd          <= rd_n;
      hc          <= hc_n;
      rom_en_o    <= rom_en_n;
      rom_addr_o  <= rom_addr_n;
      imem_we_o   <= rom_en_o;
      imem_addr_o <= ADDR_W'(BOOT_BASE) + rom_addr_o;
      cpu_reset_o <= (state_n != DONE);
      busy_o      <= (state_n != DONE);
      done_o      <= (state_n == DONE);
    end
  end

  // COPY lasts W+1 cycles: W issue cycles plus one where rd==W retires the
  // last read, so DRAIN coincides with the final write being presented.
  always_comb begin
    state_n    = state;
    rd_n       = rd;
    hc_n       = hc;
    rom_en_n   = 1'b0;
    rom_addr_n = rom_addr_o;
    case (state)
      START: begin
        state_n = COPY;
        rd_n    = '0;
      end
      COPY: begin
        if (rd == RD_END) begin
          state_n = DRAIN;
        end else begin
          rom_en_n   = 1'b1;
          rom_addr_n = ADDR_W'(rd);
          rd_n       = rd + RD_W'(1);
        end
      end
      DRAIN: begin
        hc_n    = '0;
        state_n = (HOLD_CYCLES > 0) ? HOLD : DONE;
      end
      HOLD: begin
        if (hc == HC_LAST) state_n = DONE;
        else               hc_n    = hc + HC_W'(1);
      end
      DONE: begin
        if (start_i) state_n = START;
      end
      default: state_n = START;
    endcase
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: four parameterisations with ROM/imem models.
module tb_boot_sequencer;

  typedef struct {
    logic       en;
    logic [7:0] ra;
    logic       we;
    logic [7:0] ia;
    logic       cr;
    logic       dn;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, rst_c = 1'b0;
  logic start_a = 1'b0, start_c = 1'b0;
  logic clr0 = 1'b1, clr_c = 1'b1;
  int n_total = 0, n_pass = 0, prot_err = 0;

  function automatic logic [15:0] rom_fn(input logic [15:0] sel, input int unsigned a);
    return sel + 16'(a);
  endfunction

  function automatic vec_t mk(input logic en, input logic [7:0] ra, input logic we,
                              input logic [7:0] ia, input logic cr, input logic dn);
    vec_t v;
    v.en = en; v.ra = ra; v.we = we; v.ia = ia; v.cr = cr; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // A: W=4, base 0x10, H=2
  logic en_a, we_a, cr_a, bs_a, dn_a;
  logic [7:0] ra_a, ia_a;
  logic [15:0] rq_a, wd_a;
  logic [15:0] im_a [256];
  int wc_a;
  boot_sequencer #(.ADDR_W(8), .DATA_W(16), .BOOT_WORDS(4), .BOOT_BASE(16), .HOLD_CYCLES(2)) u_a (
    .clk(clk), .reset(rst_n), .start_i(start_a), .rom_en_o(en_a), .rom_addr_o(ra_a),
    .rom_data_i(rq_a), .imem_we_o(we_a), .imem_addr_o(ia_a), .imem_wdata_o(wd_a),
    .cpu_reset_o(cr_a), .busy_o(bs_a), .done_o(dn_a));

  // B: W=1, base 5, H=0
  logic en_b, we_b, cr_b, bs_b, dn_b;
  logic [3:0] ra_b, ia_b;
  logic [15:0] rq_b, wd_b;
  logic [15:0] im_b [16];
  int wc_b;
  boot_sequencer #(.ADDR_W(4), .DATA_W(16), .BOOT_WORDS(1), .BOOT_BASE(5), .HOLD_CYCLES(0)) u_b (
    .clk(clk), .reset(rst_n), .start_i(1'b0), .rom_en_o(en_b), .rom_addr_o(ra_b),
    .rom_data_i(rq_b), .imem_we_o(we_b), .imem_addr_o(ia_b), .imem_wdata_o(wd_b),
    .cpu_reset_o(cr_b), .busy_o(bs_b), .done_o(dn_b));

  // C: W=8, base 3, H=1 (mid-copy reset and restart)
  logic en_c, we_c, cr_c, bs_c, dn_c;
  logic [5:0] ra_c, ia_c;
  logic [15:0] rq_c, wd_c;
  logic [15:0] im_c [64];
  int wc_c;
  boot_sequencer #(.ADDR_W(6), .DATA_W(16), .BOOT_WORDS(8), .BOOT_BASE(3), .HOLD_CYCLES(1)) u_c (
    .clk(clk), .reset(rst_c), .start_i(start_c), .rom_en_o(en_c), .rom_addr_o(ra_c),
    .rom_data_i(rq_c), .imem_we_o(we_c), .imem_addr_o(ia_c), .imem_wdata_o(wd_c),
    .cpu_reset_o(cr_c), .busy_o(bs_c), .done_o(dn_c));

  // D: whole 8-word address space, base 0, H=0
  logic en_d, we_d, cr_d, bs_d, dn_d;
  logic [2:0] ra_d, ia_d;
  logic [15:0] rq_d, wd_d;
  logic [15:0] im_d [8];
  int wc_d;
  boot_sequencer #(.ADDR_W(3), .DATA_W(16), .BOOT_WORDS(8), .BOOT_BASE(0), .HOLD_CYCLES(0)) u_d (
    .clk(clk), .reset(rst_n), .start_i(1'b0), .rom_en_o(en_d), .rom_addr_o(ra_d),
    .rom_data_i(rq_d), .imem_we_o(we_d), .imem_addr_o(ia_d), .imem_wdata_o(wd_d),
    .cpu_reset_o(cr_d), .busy_o(bs_d), .done_o(dn_d));

  // ROM: data valid the cycle after the enable cycle; imem commits on the edge after we
  always @(posedge clk) begin
    if (en_a) rq_a <= rom_fn(16'h00A0, 32'(ra_a));
    if (en_b) rq_b <= rom_fn(16'hB700, 32'(ra_b));
    if (en_c) rq_c <= rom_fn(16'hC300, 32'(ra_c));
    if (en_d) rq_d <= rom_fn(16'hD100, 32'(ra_d));
    if (clr0) begin
      for (int i = 0; i < 256; i++) im_a[i] <= 16'h0;
      for (int i = 0; i < 16; i++) im_b[i] <= 16'h0;
      for (int i = 0; i < 8; i++) im_d[i] <= 16'h0;
      wc_a <= 0; wc_b <= 0; wc_d <= 0;
    end else begin
      if (we_a) begin im_a[ia_a] <= wd_a; wc_a <= wc_a + 1; end
      if (we_b) begin im_b[ia_b] <= wd_b; wc_b <= wc_b + 1; end
      if (we_d) begin im_d[ia_d] <= wd_d; wc_d <= wc_d + 1; end
    end
    if (clr_c) begin
      for (int i = 0; i < 64; i++) im_c[i] <= 16'h0;
      wc_c <= 0;
    end else if (we_c) begin
      im_c[ia_c] <= wd_c; wc_c <= wc_c + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bs_a !== ~dn_a || (we_a && dn_a)) begin prot_err++; $display("FAIL protocol_a: busy=%b done=%b we=%b", bs_a, dn_a, we_a); end
      if (bs_b !== ~dn_b || (we_b && dn_b)) begin prot_err++; $display("FAIL protocol_b: busy=%b done=%b we=%b", bs_b, dn_b, we_b); end
      if (bs_d !== ~dn_d || (we_d && dn_d)) begin prot_err++; $display("FAIL protocol_d: busy=%b done=%b we=%b", bs_d, dn_d, we_d); end
    end
    if (rst_c) begin
      if (bs_c !== ~dn_c || (we_c && dn_c)) begin prot_err++; $display("FAIL protocol_c: busy=%b done=%b we=%b", bs_c, dn_c, we_c); end
    end
  end

  vec_t tab_a [10];
  vec_t tab_b [10];

  initial begin
    tab_a[0] = mk(0, 8'h00, 0, 8'h00, 1, 0);
    tab_a[1] = mk(1, 8'h00, 0, 8'h00, 1, 0);
    tab_a[2] = mk(1, 8'h01, 1, 8'h10, 1, 0);
    tab_a[3] = mk(1, 8'h02, 1, 8'h11, 1, 0);
    tab_a[4] = mk(1, 8'h03, 1, 8'h12, 1, 0);
    tab_a[5] = mk(0, 8'h00, 1, 8'h13, 1, 0);
    tab_a[6] = mk(0, 8'h00, 0, 8'h00, 1, 0);
    tab_a[7] = mk(0, 8'h00, 0, 8'h00, 1, 0);
    tab_a[8] = mk(0, 8'h00, 0, 8'h00, 0, 1);
    tab_a[9] = mk(0, 8'h00, 0, 8'h00, 0, 1);
    tab_b[0] = mk(0, 8'h00, 0, 8'h00, 1, 0);
    tab_b[1] = mk(1, 8'h00, 0, 8'h00, 1, 0);
    tab_b[2] = mk(0, 8'h00, 1, 8'h05, 1, 0);
    for (int k = 3; k < 10; k++) tab_b[k] = mk(0, 8'h00, 0, 8'h00, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    clr0 = 1'b0;
    chk("reset_vals_a", {en_a, ra_a, we_a, ia_a, cr_a, bs_a, dn_a}, {1'b0, 8'h00, 1'b0, 8'h00, 3'b110});
    chk("reset_vals_c", {en_c, ra_c, we_c, ia_c, cr_c, bs_c, dn_c}, {1'b0, 6'h00, 1'b0, 6'h00, 3'b110});

    // Table-driven: A and B, cycle by cycle after edges 0..9
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("a_e%0d_ctl", k), {en_a, we_a, cr_a, dn_a}, {tab_a[k].en, tab_a[k].we, tab_a[k].cr, tab_a[k].dn});
      if (tab_a[k].en) chk($sformatf("a_e%0d_raddr", k), 64'(ra_a), 64'(tab_a[k].ra));
      if (tab_a[k].we) chk($sformatf("a_e%0d_waddr", k), 64'(ia_a), 64'(tab_a[k].ia));
      chk($sformatf("b_e%0d_ctl", k), {en_b, we_b, cr_b, dn_b}, {tab_b[k].en, tab_b[k].we, tab_b[k].cr, tab_b[k].dn});
      if (tab_b[k].en) chk($sformatf("b_e%0d_raddr", k), 64'(ra_b), 64'(tab_b[k].ra));
      if (tab_b[k].we) chk($sformatf("b_e%0d_waddr", k), 64'(ia_b), 64'(tab_b[k].ia));
    end
    for (int i = 0; i < 4; i++) chk($sformatf("a_imem_%0d", i), 64'(im_a[16 + i]), 64'(16'h00A0 + 16'(i)));
    chk("a_write_count", 64'(wc_a), 64'd4);
    chk("b_imem_5", 64'(im_b[5]), 64'(16'hB700));
    chk("b_write_count", 64'(wc_b), 64'd1);

    // D: full address space, expected done after edge 10
    repeat (3) @(posedge clk);
    #1;
    chk("d_done", {cr_d, dn_d}, 2'b01);
    for (int i = 0; i < 8; i++) chk($sformatf("d_imem_%0d", i), 64'(im_d[i]), 64'(rom_fn(16'hD100, i)));
    chk("d_write_count", 64'(wc_d), 64'd8);

    // C: reset asserted after edge 3 of the copy
    @(negedge clk) begin rst_c = 1'b1; clr_c = 1'b0; end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) chk("c_first_read", {en_c, ra_c}, {1'b1, 6'd0});
    end
    chk("c_e3_read", {en_c, ra_c, we_c, ia_c}, {1'b1, 6'd2, 1'b1, 6'd4});
    @(negedge clk) rst_c = 1'b0;
    #1;
    chk("c_async_reset", {en_c, ra_c, we_c, ia_c, cr_c, bs_c, dn_c}, {1'b0, 6'h00, 1'b0, 6'h00, 3'b110});
    clr_c = 1'b1;
    @(posedge clk);
    #1;
    clr_c = 1'b0;
    @(negedge clk) rst_c = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) chk("c_restart_addr0", {en_c, ra_c}, {1'b1, 6'd0});
      if (k == 3) start_c = 1'b1;
      if (k == 4) begin
        start_c = 1'b0;
        chk("c_start_ignored", {en_c, ra_c, cr_c}, {1'b1, 6'd3, 1'b1});
      end
      if (k == 9) chk("c_last_write", {we_c, ia_c}, {1'b1, 6'd10});
      if (k == 10) chk("c_e10_hold", {we_c, cr_c, dn_c}, 3'b010);
      if (k == 11) chk("c_e11_done", {cr_c, bs_c, dn_c}, 3'b001);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("c_imem_%0d", i), 64'(im_c[3 + i]), 64'(rom_fn(16'hC300, i)));
    chk("c_write_count", 64'(wc_c), 64'd8);

    // C: start_i in DONE triggers a full recopy
    clr_c = 1'b1;
    @(posedge clk);
    #1;
    clr_c = 1'b0;
    start_c = 1'b1;
    @(posedge clk);
    #1;
    start_c = 1'b0;
    chk("c_start_in_done", {cr_c, bs_c, dn_c, en_c}, 4'b1100);
    for (int n = 0; n < 50 && !dn_c; n++) begin
      @(posedge clk);
      #1;
    end
    chk("c_recopy_done", {cr_c, dn_c}, 2'b01);
    for (int i = 0; i < 8; i++) chk($sformatf("c_recopy_imem_%0d", i), 64'(im_c[3 + i]), 64'(rom_fn(16'hC300, i)));
    chk("c_recopy_count", 64'(wc_c), 64'd8);

    chk("protocol_errors", 64'(prot_err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
